// File: rtl/rooth_dmem_arbiter.sv
// rooth_dmem_arbiter: two-master arbiter/sequencer for the rooth_soc data_mem port.
// M0 = core LSU, M1 = debug/loader. One slave access at a time:
// IDLE -> ISSUE (s_en, gnt) -> WAIT (RD_LAT cycles) -> RESP (rvalid) -> IDLE.
// Ports: clk, rst_n (async, active low); mN_req/we/addr/wdata/wstrb in,
// mN_gnt/rvalid/rdata out (N=0,1); s_en/we/addr/wdata/wstrb out, s_rdata in.
// Option: ROOTH_DMEM_ARB_RR_EN selects round-robin, else fixed M0 priority.
module rooth_dmem_arbiter #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            m0_req,
   input  logic            m0_we,
   input  logic [AW-1:0]   m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   input  logic [DW/8-1:0] m0_wstrb,
   output logic            m0_gnt,
   output logic            m0_rvalid,
   output logic [DW-1:0]   m0_rdata,
   input  logic            m1_req,
   input  logic            m1_we,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   input  logic [DW/8-1:0] m1_wstrb,
   output logic            m1_gnt,
   output logic            m1_rvalid,
   output logic [DW-1:0]   m1_rdata,
   output logic            s_en,
   output logic            s_we,
   output logic [AW-1:0]   s_addr,
   output logic [DW-1:0]   s_wdata,
   output logic [DW/8-1:0] s_wstrb,
   input  logic [DW-1:0]   s_rdata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

   logic [1:0]      state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            owner_q;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW/8-1:0] wstrb_q;
   logic [DW-1:0]   rdata_q;
   logic            win;
   logic            any_req;
   logic            issue;
   logic            resp;

   assign any_req = m0_req | m1_req;

`ifdef ROOTH_DMEM_ARB_RR_EN
   // prio_q names the master that wins a tie; it flips away from each grantee.
   logic prio_q;
   assign win = m1_req & (~m0_req | prio_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= 1'b0;
      end else if (state_q == S_ISSUE) begin
         prio_q <= ~owner_q;
      end
   end
`else
   assign win = m1_req & ~m0_req;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 3'd0) state_d = S_RESP;
            else cnt_d = cnt_q - 3'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == S_IDLE && any_req) begin
            owner_q <= win;
            we_q    <= win ? m1_we    : m0_we;
            addr_q  <= win ? m1_addr  : m0_addr;
            wdata_q <= win ? m1_wdata : m0_wdata;
            wstrb_q <= win ? m1_wstrb : m0_wstrb;
         end
         // Writes report zero data with their completion pulse.
         if (state_q == S_WAIT && cnt_q == 3'd0) begin
            rdata_q <= we_q ? '0 : s_rdata;
         end
      end
   end

   assign issue = (state_q == S_ISSUE);
   assign resp  = (state_q == S_RESP);

   assign m0_gnt    = issue & ~owner_q;
   assign m1_gnt    = issue &  owner_q;
   assign m0_rvalid = resp  & ~owner_q;
   assign m1_rvalid = resp  &  owner_q;
   assign m0_rdata  = m0_rvalid ? rdata_q : '0;
   assign m1_rdata  = m1_rvalid ? rdata_q : '0;

   assign s_en    = issue;
   assign s_we    = we_q;
   assign s_addr  = addr_q;
   assign s_wdata = wdata_q;
   assign s_wstrb = wstrb_q;

endmodule
